// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master with illegal-select and timeout error responses
module apb_master_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        Reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_sel,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_sel,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic        PREADY1,
  input  logic        PREADY2
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic last_grant, write_q, id_q, pready, legal, timeout, busy;
  logic [1:0] sel_q, grant, gsel;
  logic [4:0] addr_q;
  logic [31:0] wdata_q, prdata;
  logic [7:0] cnt;
  always_comb begin
    grant = (state == IDLE && !Reset) ?
      {req1_valid && (!req0_valid || !last_grant), req0_valid && (!req1_valid || last_grant)} : 2'b00;
    gsel = grant[1] ? req1_sel : req0_sel;
    legal = gsel == 2'b01 || gsel == 2'b10;
    pready = sel_q[0] ? PREADY1 : PREADY2;
    prdata = sel_q[0] ? PRDATA1 : PRDATA2;
    timeout = !pready && cnt == 8'(TIMEOUT - 1);
    state_nx = state == IDLE ? ((|grant && legal) ? SETUP : IDLE) :
               state == SETUP ? ACCESS : ((pready || timeout) ? IDLE : ACCESS);
    busy = state != IDLE;
    req_ready = grant;
    PSEL = busy ? sel_q : 2'b00;
    PENABLE = state == ACCESS;
    PWRITE = busy && write_q;
    PADDR = busy ? addr_q : 5'd0;
    PWDATA = busy ? wdata_q : 32'd0;
  end
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      last_grant <= 1'b1;
      cnt <= 8'd0;
      id_q <= 1'b0;
      write_q <= 1'b0;
      sel_q <= 2'b00;
      addr_q <= 5'd0;
      wdata_q <= 32'd0;
      rsp_done <= 2'b00;
      rsp_err <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_done <= 2'b00;
      rsp_err <= 1'b0;
      rsp_rdata <= 32'd0;
      if (|grant) begin
        last_grant <= grant[1];
        id_q <= grant[1];
        write_q <= grant[1] ? req1_write : req0_write;
        sel_q <= gsel;
        addr_q <= grant[1] ? req1_addr : req0_addr;
        wdata_q <= grant[1] ? req1_wdata : req0_wdata;
        if (!legal) begin
          rsp_done <= grant;
          rsp_err <= 1'b1;
        end
      end
      if (state == SETUP) cnt <= 8'd0;
      if (state == ACCESS) begin
        if (!pready) cnt <= cnt + 8'd1;
        if (pready || timeout) begin
          rsp_done <= id_q ? 2'b10 : 2'b01;
          rsp_err <= !pready;
          rsp_rdata <= (pready && !write_q) ? prdata : 32'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: table-driven scoreboard bench with a programmable-wait APB slave model
module tb_apb_master_arbiter;
  localparam int TO = 16;
  typedef struct {
    logic        v0;
    logic        v1;
    logic        wr;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          wt;
  } vec_t;
  typedef struct {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  logic pclk = 1'b0, Reset = 1'b1;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [1:0] req0_sel = 2'b00, req1_sel = 2'b00;
  logic [4:0] req0_addr = 5'd0, req1_addr = 5'd0;
  logic [31:0] req0_wdata = 32'd0, req1_wdata = 32'd0;
  logic [1:0] req_ready, rsp_done, PSEL;
  logic [31:0] rsp_rdata, PWDATA, PRDATA1, PRDATA2;
  logic rsp_err, PENABLE, PWRITE, PREADY1, PREADY2;
  logic [4:0] PADDR;
  exp_t q[$];
  vec_t tv[10];
  vec_t cv, rv, fv;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc = 0, gt = -100, due = -100, wt_cur = 0;
  logic last = 1'b1, cur_legal = 1'b0, cur_wr = 1'b0;
  logic [1:0] cur_sel = 2'b00;
  logic [4:0] cur_addr = 5'd0;
  logic [31:0] cur_wdata = 32'd0, pr_cur = 32'd0;
  apb_master_arbiter #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_sel(req0_sel),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_sel(req1_sel),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req_ready(req_ready), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  always @(posedge pclk or posedge Reset) begin
    if (Reset) acc <= 0;
    else acc <= PENABLE ? acc + 1 : 0;
  end
  assign PREADY1 = (PSEL == 2'b01 && PENABLE) ? (acc >= wt_cur) : 1'b1;
  assign PREADY2 = (PSEL == 2'b10 && PENABLE) ? (acc >= wt_cur) : 1'b1;
  assign PRDATA1 = PSEL == 2'b01 ? pr_cur : 32'hDEAD_BEEF;
  assign PRDATA2 = PSEL == 2'b10 ? pr_cur : 32'hBAD0_F00D;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask
  always @(negedge pclk) begin : mon
    exp_t e;
    logic act;
    if (!Reset) begin
      act = cur_legal && cyc > gt && cyc < due;
      chk("psel", 32'(PSEL), act ? 32'(cur_sel) : 32'd0);
      chk("penable", 32'(PENABLE), 32'(act && cyc >= gt + 2));
      chk("pwrite", 32'(PWRITE), 32'(act && cur_wr));
      chk("paddr", 32'(PADDR), act ? 32'(cur_addr) : 32'd0);
      chk("pwdata", PWDATA, act ? cur_wdata : 32'd0);
      if (rsp_done != 2'b00) begin
        if (q.size() == 0) chk("spurious_done", 32'(rsp_done), 32'd0);
        else begin
          e = q.pop_front();
          chk("rsp_done", 32'(rsp_done), 32'(e.done));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("latency", cyc, e.due);
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        chk("missing_done", 32'(rsp_done), 32'(q[0].done));
        void'(q.pop_front());
      end
    end
  end
  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge pclk);
    if (q.size() != 0) begin
      chk("drain", q.size(), 32'd0);
      q.delete();
    end
  endtask
  task automatic run(input vec_t v, input bit hold);
    logic [1:0] g;
    logic leg, tmo;
    int lat;
    exp_t e;
    req0_valid = v.v0;
    req1_valid = v.v1;
    req0_write = v.v0 ? v.wr : !v.wr;
    req1_write = v.v1 ? v.wr : !v.wr;
    req0_sel = v.v0 ? v.sel : 2'b10;
    req1_sel = v.v1 ? v.sel : 2'b10;
    req0_addr = v.v0 ? v.addr : ~v.addr;
    req1_addr = v.v1 ? v.addr : ~v.addr;
    req0_wdata = v.v0 ? v.wdata : ~v.wdata;
    req1_wdata = v.v1 ? v.wdata : ~v.wdata;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready != 2'b00) break;
      @(negedge pclk);
      #1;
    end
    g = (v.v0 && v.v1) ? (last ? 2'b01 : 2'b10) : {v.v1, v.v0};
    chk("req_ready", 32'(req_ready), 32'(g));
    last = g[1];
    if (req_ready == g) begin
      leg = v.sel == 2'b01 || v.sel == 2'b10;
      tmo = leg && v.wt >= TO;
      lat = !leg ? 1 : tmo ? TO + 2 : 3 + v.wt;
      cur_legal = leg;
      cur_sel = v.sel;
      cur_wr = v.wr;
      cur_addr = v.addr;
      cur_wdata = v.wdata;
      wt_cur = v.wt;
      pr_cur = v.prdata;
      gt = cyc;
      due = cyc + lat;
      e.done = g;
      e.err = !leg || tmo;
      e.rdata = (leg && !tmo && !v.wr) ? v.prdata : 32'd0;
      e.due = cyc + lat;
      q.push_back(e);
    end
    @(negedge pclk);
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_psel"}, 32'(PSEL), 32'd0);
    chk({n, "_penable"}, 32'(PENABLE), 32'd0);
    chk({n, "_pwrite"}, 32'(PWRITE), 32'd0);
    chk({n, "_paddr"}, 32'(PADDR), 32'd0);
    chk({n, "_pwdata"}, PWDATA, 32'd0);
    chk({n, "_rsp_done"}, 32'(rsp_done), 32'd0);
    chk({n, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({n, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({n, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b1, 2'b01, 5'd1,  32'hABCD1234, 32'h0,        0};
    tv[1] = '{1'b0, 1'b1, 1'b0, 2'b01, 5'd2,  32'h0,        32'h00000AAA, 2};
    tv[2] = '{1'b1, 1'b0, 1'b1, 2'b11, 5'd3,  32'h11111111, 32'h0,        0};
    tv[3] = '{1'b0, 1'b1, 1'b0, 2'b00, 5'd4,  32'h0,        32'h0,        0};
    tv[4] = '{1'b1, 1'b0, 1'b1, 2'b10, 5'd5,  32'h5A5A5A5A, 32'h0,        1000};
    tv[5] = '{1'b0, 1'b1, 1'b0, 2'b10, 5'd6,  32'h0,        32'hCAFEF00D, TO - 1};
    tv[6] = '{1'b1, 1'b0, 1'b0, 2'b10, 5'd7,  32'h0,        32'h12345678, 1};
    tv[7] = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd8,  32'h0,        32'h87654321, 0};
    tv[8] = '{1'b1, 1'b1, 1'b1, 2'b10, 5'd9,  32'h0F0F0F0F, 32'h0,        3};
    tv[9] = '{1'b0, 1'b1, 1'b1, 2'b01, 5'd31, 32'hFFFFFFFF, 32'h0,        TO};
    cv = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd10, 32'h0, 32'h000055AA, 0};
    rv = '{1'b1, 1'b0, 1'b1, 2'b10, 5'd12, 32'h600DD00D, 32'h0, 1000};
    fv = '{1'b0, 1'b1, 1'b0, 2'b01, 5'd13, 32'h0, 32'h0BADCAFE, 1};
    #3;
    chk_zero("reset");
    repeat (2) @(negedge pclk);
    Reset = 1'b0;
    @(negedge pclk);
    for (int k = 0; k < 4; k++) run(cv, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    for (int k = 0; k < 10; k++) run(tv[k], 1'b0);
    run(rv, 1'b1);
    repeat (2) @(negedge pclk);
    #2;
    Reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    q.delete();
    cur_legal = 1'b0;
    gt = -100;
    due = -100;
    last = 1'b1;
    repeat (2) @(negedge pclk);
    #1;
    chk("held_reset_req_ready", 32'(req_ready), 32'd0);
    req0_valid = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge pclk);
    run(fv, 1'b0);
    repeat (3) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
